field_op_unit: RTL and testbench
================================

FIELD_OP_UNIT -- requirements
Module: field_op_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter BEAT_BYTES, default 4: bytes per memory beat (1, 2, 4 or 8); data width DW = 8*BEAT_BYTES.
REQ-003 SHALL have parameter LEN_W, default 8: field-length width in bytes.
REQ-004 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  level request, held until ready_o seen
- op_i  in  2  0=COPY, 1=ADD_IMM, 2=SET_IMM, 3=reserved
- src_addr_i  in  ADDR_W  source byte address (COPY, ADD_IMM)
- dst_addr_i  in  ADDR_W  destination byte address
- len_i  in  LEN_W  field length in bytes
- imm_i  in  DW  immediate; sign-extended by caller
- mem_ce_o  out  1  memory request
- mem_we_o  out  1  1=write
- mem_addr_o  out  ADDR_W  byte address
- mem_width_o  out  4  bytes in this beat, 1..BEAT_BYTES
- mem_data_o  out  DW  write data, right-aligned
- mem_data_i  in  DW  read data, right-aligned
- mem_ack_i  in  1  request accepted; read data valid this cycle
- ready_o  out  1  operation finished
- err_o  out  1  operation rejected; valid with ready_o

Function
REQ-005 SHALL use states IDLE, LOAD, STORE, DONE.
REQ-006 IDLE: on start_i=1, SHALL latch op_i, addresses, len_i and imm_i and decode next cycle; inputs are ignored thereafter until IDLE.
REQ-007 Error cases SHALL go directly to DONE with err_o=1 and no memory access:
- op_i=3
- ADD_IMM or SET_IMM with len_i=0 or len_i>BEAT_BYTES
REQ-008 COPY with len_i=0 SHALL go directly to DONE with err_o=0 and no memory access.
REQ-009 COPY SHALL loop LOAD->STORE per beat:
- beat width = min(remaining, BEAT_BYTES)
- src/dst pointers and remaining count advance by that width after each STORE ack
- forward order only; overlap behaviour is exactly that sequential order
REQ-010 ADD_IMM SHALL perform one LOAD and one STORE.
- store data = (loaded + imm_i) modulo 2^(8*len)
- bytes above len in mem_data_o SHALL be zero
REQ-011 SET_IMM SHALL perform one STORE of imm_i truncated to len bytes, skipping LOAD.
REQ-012 Memory request rules:
- mem_ce_o, mem_we_o, mem_addr_o, mem_width_o and mem_data_o SHALL be held stable from assertion until the cycle mem_ack_i=1.
- mem_ce_o SHALL drop the cycle after ack unless the next request issues back-to-back.
- mem_ack_i while mem_ce_o=0 SHALL be ignored.
REQ-013 Minimum latency with zero-wait ack, start_i high to ready_o:
- COPY: 2+2*ceil(len/BEAT_BYTES) cycles
- ADD_IMM: 4 cycles
- SET_IMM: 3 cycles
REQ-014 DONE: ready_o=1 (and err_o if rejected) SHALL be held until start_i=0, then the unit returns to IDLE with ready_o=err_o=0 the next cycle.
REQ-015 start_i deasserted mid-operation SHALL NOT abort; the unit completes, then leaves DONE at once.

Reset
REQ-016 rst=1 SHALL immediately, asynchronously:
- set the state to IDLE
- clear all outputs to zero: mem_ce_o, mem_we_o, ready_o, err_o, mem_addr_o, mem_width_o, mem_data_o
- clear the latched operands
REQ-017 Reset mid-beat SHALL abandon the request; the first post-reset cycle SHALL drive mem_ce_o=0.

Configuration
REQ-018 Macro FIELD_OP_SAT_ADD_EN: when defined, ADD_IMM SHALL saturate.
- signed overflow clamps to the len-byte signed max/min per the sign of imm_i
- without the macro, ADD_IMM wraps per REQ-010

Structure
REQ-019 Op-code constants and state encodings SHALL reside in the shared definitions header alongside the existing opcode and state defines.
REQ-020 Beat width and pointer advance SHALL be computed in a sub-module field_beat_calc (remaining, BEAT_BYTES -> width, last flag).

Verification
REQ-021 Directed scenarios (BEAT_BYTES=4, zero-wait ack unless stated):
- COPY src=0x10 dst=0x40 len=10 -> widths 4,4,2; dst bytes 0x40..0x49 equal source; ready_o at cycle 8.
- ADD_IMM addr=0x20 len=2, mem=0xFFFE, imm=3 -> store 0x0001 (wrap); with FIELD_OP_SAT_ADD_EN, store 0x7FFF only if the signed-overflow rule fires, else 0x0001.
- SET_IMM len=5 -> ready_o=1, err_o=1, no mem_ce_o pulse.
- COPY len=6 with ack delayed 3 cycles per beat -> request fields stable across wait; widths 4,2.
- rst asserted during second COPY beat -> mem_ce_o=0 and ready_o=0 immediately; new start completes normally.

Source files
------------

// File: rtl/field_op_unit_pkg.sv
// Shared opcodes, FSM state encoding and byte-mask helper for field_op_unit.
package field_op_unit_pkg;

  typedef enum logic [1:0] {
    OP_COPY    = 2'd0,
    OP_ADD_IMM = 2'd1,
    OP_SET_IMM = 2'd2,
    OP_RSVD    = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_BEAT_BYTES = 8;
  localparam int MAX_DW         = 8 * MAX_BEAT_BYTES;

  // Low nbytes bytes set, upper bytes clear.
  function automatic logic [MAX_DW-1:0] byte_mask(input logic [3:0] nbytes);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BEAT_BYTES; i++) begin
      if (i < int'(nbytes)) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/field_beat_calc.sv
// Beat sizing for a field walk: width of the next beat, last-beat flag and
// the pointers/remaining count after that beat completes.
module field_beat_calc #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 4,
  parameter int LEN_W      = 8
) (
  input  logic [LEN_W-1:0]  remaining,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [3:0]        width,
  output logic              last,
  output logic [ADDR_W-1:0] next_src,
  output logic [ADDR_W-1:0] next_dst,
  output logic [LEN_W-1:0]  next_remaining
);

  localparam logic [LEN_W-1:0] BEAT_LEN = LEN_W'(BEAT_BYTES);

  always_comb begin
    last           = (remaining <= BEAT_LEN);
    width          = last ? 4'(remaining) : 4'(BEAT_BYTES);
    next_src       = src_addr + ADDR_W'(width);
    next_dst       = dst_addr + ADDR_W'(width);
    next_remaining = remaining - LEN_W'(width);
  end

endmodule

// File: rtl/field_op_unit.sv
// Byte-field COPY / ADD_IMM / SET_IMM engine over a beat-wide memory port.
// Define FIELD_OP_SAT_ADD_EN to make ADD_IMM saturate on signed overflow.
module field_op_unit
  import field_op_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 4,
  parameter int LEN_W      = 8,
  localparam int DW        = 8 * BEAT_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DW-1:0]     imm_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DW-1:0]     mem_data_o,
  input  logic [DW-1:0]     mem_data_i,
  input  logic              mem_ack_i,
  output logic              ready_o,
  output logic              err_o,
  output logic [1:0]        dbg_state
);

  localparam logic [LEN_W-1:0] BEAT_LEN = LEN_W'(BEAT_BYTES);

  // Memory handshake: a request (ce plus we/addr/width/data) is presented
  // from a registered state and held until the cycle mem_ack_i=1; that edge
  // retires it. mem_ack_i outside LOAD/STORE has no effect.

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DW-1:0]     imm_q, imm_d, wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [3:0]        beat_width;
  logic              beat_last;
  logic [ADDR_W-1:0] next_src, next_dst;
  logic [LEN_W-1:0]  next_rem;

  logic [DW-1:0]     beat_mask, load_val, sum_val, add_res;
`ifdef FIELD_OP_SAT_ADD_EN
  logic [DW-1:0]     sign_mask;
  logic              a_neg, b_neg, s_neg;
`endif

  field_beat_calc #(
    .ADDR_W    (ADDR_W),
    .BEAT_BYTES(BEAT_BYTES),
    .LEN_W     (LEN_W)
  ) u_beat_calc (
    .remaining     (rem_q),
    .src_addr      (src_q),
    .dst_addr      (dst_q),
    .width         (beat_width),
    .last          (beat_last),
    .next_src      (next_src),
    .next_dst      (next_dst),
    .next_remaining(next_rem)
  );

  // For ADD/SET the remaining count equals len (<= BEAT_BYTES), so the beat
  // width doubles as the field width.
  always_comb begin
    beat_mask = DW'(byte_mask(beat_width));
    load_val  = mem_data_i & beat_mask;
    sum_val   = (load_val + imm_q) & beat_mask;
    add_res   = sum_val;
`ifdef FIELD_OP_SAT_ADD_EN
    sign_mask = beat_mask & ~(beat_mask >> 1);
    a_neg     = |(load_val & sign_mask);
    b_neg     = |(imm_q & sign_mask);
    s_neg     = |(sum_val & sign_mask);
    if ((a_neg == b_neg) && (s_neg != a_neg)) begin
      add_res = b_neg ? sign_mask : (beat_mask >> 1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    imm_d   = imm_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (op_q == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (op_q == OP_COPY) begin
            state_d = (rem_q == '0) ? DONE : LOAD;
          end else if ((rem_q == '0) || (rem_q > BEAT_LEN)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (op_q == OP_SET_IMM) begin
            wdata_d = imm_q & beat_mask;
            state_d = STORE;
          end else begin
            state_d = LOAD;
          end
        end else if (start_i) begin
          pend_d = 1'b1;
          op_d   = op_t'(op_i);
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          rem_d  = len_i;
          imm_d  = imm_i;
          err_d  = 1'b0;
        end
      end
      LOAD: begin
        if (mem_ack_i) begin
          wdata_d = (op_q == OP_ADD_IMM) ? add_res : load_val;
          state_d = STORE;
        end
      end
      STORE: begin
        if (mem_ack_i) begin
          src_d   = next_src;
          dst_d   = next_dst;
          rem_d   = next_rem;
          state_d = beat_last ? DONE : LOAD;
        end
      end
      DONE: begin
        if (!start_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      imm_q   <= imm_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    mem_ce_o    = (state_q == LOAD) || (state_q == STORE);
    mem_we_o    = (state_q == STORE);
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    if (state_q == LOAD) begin
      mem_addr_o  = src_q;
      mem_width_o = beat_width;
    end else if (state_q == STORE) begin
      mem_addr_o  = dst_q;
      mem_width_o = beat_width;
      mem_data_o  = wdata_q;
    end
    ready_o   = (state_q == DONE);
    err_o     = (state_q == DONE) && err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_field_op_unit.sv
// Scoreboard bench for field_op_unit: byte-array memory responder, reference
// model of field operations, write-beat/completion monitor.
module tb_field_op_unit;
  import field_op_unit_pkg::*;

  localparam int W_ENT = 68;

  logic        clk, rst, start_i;
  logic [1:0]  op_i;
  logic [31:0] src_addr_i, dst_addr_i, imm_i;
  logic [7:0]  len_i;
  logic        mem_ce_o, mem_we_o, mem_ack_i, ready_o, err_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [3:0]  mem_width_o;
  logic [1:0]  dbg_state;

  field_op_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i), .imm_i(imm_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .ready_o(ready_o), .err_o(err_o), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cur_delay = 0;
  int wr_cnt = 0;
  logic [7:0] mem [256];
  logic [7:0] model_mem [256];
  logic [W_ENT-1:0] exp_q[$];
  logic [0:0] exp_err_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // memory responder: ack after cur_delay wait cycles, checks request hold
  initial begin : responder
    int age;
    logic [68:0] snap;
    age = 0;
    snap = '0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack_i = 1'b0;
        age = 0;
      end else if (!mem_ce_o) begin
        mem_ack_i = 1'($urandom_range(0, 1));
        mem_data_i = $urandom;
        age = 0;
      end else begin
        if (age == 0) snap = {mem_we_o, mem_addr_o, mem_width_o, mem_data_o};
        else check("req_stable", 64'({mem_we_o, mem_addr_o, mem_width_o, mem_data_o} != snap), 64'd0);
        if (age >= cur_delay) begin
          mem_ack_i = 1'b1;
          age = 0;
          if (mem_we_o) begin
            for (int i = 0; i < int'(mem_width_o); i++)
              mem[8'(mem_addr_o + 32'(i))] = mem_data_o[8*i +: 8];
          end else begin
            mem_data_i = '0;
            for (int i = 0; i < int'(mem_width_o); i++)
              mem_data_i[8*i +: 8] = mem[8'(mem_addr_o + 32'(i))];
          end
        end else begin
          mem_ack_i = 1'b0;
          mem_data_i = $urandom;
          age++;
        end
      end
    end
  end

  // monitor: pops expected write beats and completions
  initial begin : monitor
    logic prev_ready;
    logic [W_ENT-1:0] e;
    logic [0:0] ee;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mem_ce_o && mem_we_o && mem_ack_i) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL write_beat: unexpected write addr=%0h w=%0d data=%0h", mem_addr_o, mem_width_o, mem_data_o);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if ({mem_addr_o, mem_width_o, mem_data_o} !== e) begin
            n_fail++;
            $display("FAIL write_beat: got addr=%0h w=%0d data=%0h expected addr=%0h w=%0d data=%0h",
                     mem_addr_o, mem_width_o, mem_data_o, e[67:36], e[35:32], e[31:0]);
          end
        end
      end
      if (ready_o && !prev_ready) begin
        if (exp_err_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL completion: unexpected ready_o, err_o=%0b", err_o);
        end else begin
          ee = exp_err_q.pop_front();
          check("err_o", 64'(err_o), 64'(ee));
        end
      end
      prev_ready = ready_o;
    end
  end

  // reference model: applies the whole operation to model_mem, queues expectations
  task automatic model_op(input logic [1:0] op, input logic [31:0] src, dst,
                          input int len, input logic [31:0] imm, output int reqs);
    logic [7:0] tmp [4];
    logic [31:0] data;
    longint ld, im, sum, mask, half, sa, sb, ss;
    int rem, w;
    reqs = 0;
    if (op == 2'd3) begin
      exp_err_q.push_back(1'b1);
    end else if (op == 2'd0) begin
      rem = len;
      while (rem > 0) begin
        w = (rem > 4) ? 4 : rem;
        data = '0;
        for (int i = 0; i < w; i++) tmp[i] = model_mem[8'(src + 32'(i))];
        for (int i = 0; i < w; i++) begin
          model_mem[8'(dst + 32'(i))] = tmp[i];
          data[8*i +: 8] = tmp[i];
        end
        exp_q.push_back({dst, 4'(w), data});
        src += 32'(w);
        dst += 32'(w);
        rem -= w;
        reqs += 2;
      end
      exp_err_q.push_back(1'b0);
    end else if (len == 0 || len > 4) begin
      exp_err_q.push_back(1'b1);
    end else begin
      mask = (longint'(1) << (8 * len)) - 1;
      im = longint'(imm) & mask;
      if (op == 2'd2) begin
        sum = im;
        reqs = 1;
      end else begin
        ld = 0;
        for (int i = 0; i < len; i++) ld = ld | (longint'(model_mem[8'(src + 32'(i))]) << (8 * i));
        sum = (ld + im) & mask;
        half = longint'(1) << (8 * len - 1);
        sa = (ld >= half) ? ld - 2 * half : ld;
        sb = (im >= half) ? im - 2 * half : im;
        ss = sa + sb;
`ifdef FIELD_OP_SAT_ADD_EN
        if (ss > half - 1) sum = half - 1;
        else if (ss < -half) sum = half;
`endif
        reqs = 2;
      end
      data = 32'(sum);
      for (int i = 0; i < len; i++) model_mem[8'(dst + 32'(i))] = data[8*i +: 8];
      exp_q.push_back({dst, 4'(len), data});
      exp_err_q.push_back(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    foreach (mem[i]) model_mem[i] = mem[i];
  endtask

  // driver: one operation, start high until ready (or dropped after latch)
  task automatic do_op(input logic [1:0] op, input logic [31:0] src, dst,
                       input int len, input logic [31:0] imm, input int dly, input bit drop);
    int reqs, cyc, ce_cyc;
    bit got;
    model_op(op, src, dst, len, imm, reqs);
    cur_delay = dly;
    @(negedge clk);
    #1;
    start_i = 1'b1;
    op_i = op;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i = 8'(len);
    imm_i = imm;
    cyc = 0;
    ce_cyc = 0;
    got = 1'b0;
    while (cyc < 400 && !got) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        op_i = 2'($urandom);
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i = 8'($urandom);
        imm_i = $urandom;
        if (drop) start_i = 1'b0;
      end
      if (ready_o) got = 1'b1;
      else if (mem_ce_o) ce_cyc++;
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: no ready_o within %0d cycles (op=%0d len=%0d)", cyc, op, len);
      do_reset();
      return;
    end
    check("latency", 64'(cyc), 64'(2 + reqs * (1 + dly)));
    check("ce_cycles", 64'(ce_cyc), 64'(reqs * (1 + dly)));
    if (start_i) begin
      @(negedge clk);
      #1;
      check("ready_held", 64'(ready_o), 64'd1);
      start_i = 1'b0;
    end
    @(negedge clk);
    #1;
    check("ready_clear", 64'({ready_o, err_o}), 64'd0);
    check("idle_state", 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin : main
    int reqs;
    rst = 1'b1;
    start_i = 1'b0;
    op_i = '0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i = '0;
    imm_i = '0;
    foreach (mem[i]) begin
      mem[i] = 8'($urandom);
      model_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_ce", 64'(mem_ce_o), 64'd0);
    check("rst_we", 64'(mem_we_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_width", 64'(mem_width_o), 64'd0);
    check("rst_data", 64'(mem_data_o), 64'd0);
    check("rst_ready_err", 64'({ready_o, err_o}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // directed: COPY 10 bytes, widths 4,4,2, latency 8
    do_op(OP_COPY, 32'h10, 32'h40, 10, 32'h0, 0, 1'b0);
    for (int i = 0; i < 10; i++) check("copy_dst_byte", 64'(mem[8'h40 + 8'(i)]), 64'(mem[8'h10 + 8'(i)]));

    // directed: ADD_IMM wrap case and a signed-overflow case
    mem[8'h20] = 8'hFE; mem[8'h21] = 8'hFF;
    model_mem[8'h20] = 8'hFE; model_mem[8'h21] = 8'hFF;
    do_op(OP_ADD_IMM, 32'h20, 32'h20, 2, 32'h3, 0, 1'b0);
    check("add_wrap", 64'({mem[8'h21], mem[8'h20]}), 64'h0001);
    mem[8'h20] = 8'hFE; mem[8'h21] = 8'h7F;
    model_mem[8'h20] = 8'hFE; model_mem[8'h21] = 8'h7F;
    do_op(OP_ADD_IMM, 32'h20, 32'h20, 2, 32'h5, 0, 1'b0);
`ifdef FIELD_OP_SAT_ADD_EN
    check("add_ovf", 64'({mem[8'h21], mem[8'h20]}), 64'h7FFF);
`else
    check("add_ovf", 64'({mem[8'h21], mem[8'h20]}), 64'h8003);
`endif

    // directed: rejects and empty copy, no memory traffic
    do_op(OP_SET_IMM, 32'h0, 32'h60, 5, 32'h12345678, 0, 1'b0);
    do_op(OP_ADD_IMM, 32'h0, 32'h60, 0, 32'h1, 0, 1'b0);
    do_op(OP_RSVD, 32'h0, 32'h60, 2, 32'h1, 0, 1'b0);
    do_op(OP_COPY, 32'h0, 32'h60, 0, 32'h0, 0, 1'b1);
    do_op(OP_SET_IMM, 32'h0, 32'h61, 3, 32'hA5B6C7D8, 0, 1'b0);

    // directed: COPY 6 with 3-cycle ack wait, widths 4,2
    do_op(OP_COPY, 32'h70, 32'h90, 6, 32'h0, 3, 1'b0);

    // directed: reset during second COPY beat, then a clean COPY
    model_op(OP_COPY, 32'h80, 32'hC0, 10, 32'h0, reqs);
    cur_delay = 1;
    wr_cnt = 0;
    @(negedge clk);
    #1;
    start_i = 1'b1;
    op_i = OP_COPY;
    src_addr_i = 32'h80;
    dst_addr_i = 32'hC0;
    len_i = 8'd10;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (wr_cnt >= 1 && mem_ce_o && !mem_we_o) break;
    end
    check("second_beat_reached", 64'(wr_cnt >= 1 && mem_ce_o && !mem_we_o), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_ce", 64'(mem_ce_o), 64'd0);
    check("async_rst_ready", 64'({ready_o, err_o}), 64'd0);
    start_i = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    rst = 1'b0;
    foreach (mem[i]) model_mem[i] = mem[i];
    @(negedge clk);
    #1;
    check("post_rst_ce", 64'(mem_ce_o), 64'd0);
    do_op(OP_COPY, 32'h80, 32'hC0, 10, 32'h0, 0, 1'b0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      do_op(2'($urandom_range(0, 3)), 32'($urandom_range(0, 240)), 32'($urandom_range(0, 240)),
            $urandom_range(0, 12), $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("exp_writes_drained", 64'(exp_q.size()), 64'd0);
    check("exp_done_drained", 64'(exp_err_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
